// File: rtl/hevc_flow_scheduler.sv
// +--------------------------------------------------------------------------+
// | hevc_flow_scheduler : two-flow config/pixel front-end for top_ms (FLUX=2) |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module hevc_flow_scheduler #(
  parameter int DATA_W  = 8,
  parameter int ALPHA_W = 3,
  parameter int SIZE_W  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_valid_i,
  output logic [1:0]             cfg_ready_o,
  input  logic [2*ALPHA_W-1:0]   cfg_v_alpha_i,
  input  logic [2*ALPHA_W-1:0]   cfg_h_alpha_i,
  input  logic [2*SIZE_W-1:0]    cfg_ext_size_i,
  input  logic [1:0]             pel_valid_i,
  input  logic [2*DATA_W-1:0]    pel_data_i,
  output logic [1:0]             pel_ready_o,
  output logic [ALPHA_W:0]       v_alpha_din_o,
  output logic [ALPHA_W:0]       h_alpha_din_o,
  output logic [SIZE_W:0]        ext_size_din_o,
  output logic                   cfg_write_o,
  input  logic [1:0]             v_alpha_full_i,
  input  logic [1:0]             h_alpha_full_i,
  input  logic [1:0]             ext_size_full_i,
  output logic [DATA_W:0]        in_din_o,
  output logic                   in_write_o,
  input  logic [1:0]             in_full_i,
  output logic [1:0]             flow_busy_o,
  output logic [1:0]             flow_done_o
);

  localparam int REM_W = 2 * SIZE_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // On a tie the pointer names the winner; otherwise the lone requester wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) rr_pick = ptr ? 2'b10 : 2'b01;
    else              rr_pick = req;
  endfunction

  logic [1:0] idle_w;
  logic [1:0] stream_w;
  logic [1:0] cfg_elig;
  logic [1:0] pel_elig;
  logic [1:0] cfg_gnt;
  logic [1:0] pel_gnt;
  logic       cfg_idx;
  logic       pel_idx;

  logic              cfg_rr_q,       cfg_rr_d;
  logic              pel_rr_q,       pel_rr_d;
  logic              cfg_write_q,    cfg_write_d;
  logic [ALPHA_W:0]  v_alpha_din_q,  v_alpha_din_d;
  logic [ALPHA_W:0]  h_alpha_din_q,  h_alpha_din_d;
  logic [SIZE_W:0]   ext_size_din_q, ext_size_din_d;
  logic              in_write_q,     in_write_d;
  logic [DATA_W:0]   in_din_q,       in_din_d;

  for (genvar g = 0; g < 2; g++) begin : g_flow
    state_t            state_q;
    logic [REM_W-1:0]  rem_q;
    logic [SIZE_W-1:0] ext;

    assign ext = cfg_ext_size_i[g*SIZE_W +: SIZE_W];

    assign idle_w[g]   = (state_q == S_IDLE);
    assign stream_w[g] = (state_q == S_STREAM);
    assign cfg_elig[g] = idle_w[g] & cfg_valid_i[g] & ~v_alpha_full_i[g]
                       & ~h_alpha_full_i[g] & ~ext_size_full_i[g];
    assign pel_elig[g] = stream_w[g] & pel_valid_i[g] & ~in_full_i[g];

    assign flow_busy_o[g] = (state_q != S_IDLE);
    assign flow_done_o[g] = (state_q == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        rem_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cfg_gnt[g]) begin
              rem_q   <= REM_W'(ext) * REM_W'(ext);
              state_q <= (ext == '0) ? S_DONE : S_STREAM;
            end
          end
          S_STREAM: begin
            if (pel_gnt[g]) begin
              rem_q <= rem_q - REM_W'(1);
              if (rem_q == REM_W'(1)) state_q <= S_DONE;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg_gnt     = rr_pick(cfg_elig, cfg_rr_q);
  assign pel_gnt     = rr_pick(pel_elig, pel_rr_q);
  assign cfg_idx     = cfg_gnt[1];
  assign pel_idx     = pel_gnt[1];
  assign cfg_ready_o = cfg_gnt;
  assign pel_ready_o = pel_gnt;

  // Accelerator words are zeroed when idle so the bus never shows stale tags.
  always_comb begin
    cfg_rr_d       = cfg_rr_q;
    pel_rr_d       = pel_rr_q;
    cfg_write_d    = |cfg_gnt;
    v_alpha_din_d  = '0;
    h_alpha_din_d  = '0;
    ext_size_din_d = '0;
    in_write_d     = |pel_gnt;
    in_din_d       = '0;
    if (|cfg_gnt) begin
      cfg_rr_d       = ~cfg_rr_q;
      v_alpha_din_d  = {cfg_idx, cfg_idx ? cfg_v_alpha_i[2*ALPHA_W-1 -: ALPHA_W]
                                         : cfg_v_alpha_i[ALPHA_W-1:0]};
      h_alpha_din_d  = {cfg_idx, cfg_idx ? cfg_h_alpha_i[2*ALPHA_W-1 -: ALPHA_W]
                                         : cfg_h_alpha_i[ALPHA_W-1:0]};
      ext_size_din_d = {cfg_idx, cfg_idx ? cfg_ext_size_i[2*SIZE_W-1 -: SIZE_W]
                                         : cfg_ext_size_i[SIZE_W-1:0]};
    end
    if (|pel_gnt) begin
      pel_rr_d = ~pel_idx;
      in_din_d = {pel_idx, pel_idx ? pel_data_i[2*DATA_W-1 -: DATA_W]
                                   : pel_data_i[DATA_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rr_q       <= 1'b0;
      pel_rr_q       <= 1'b0;
      cfg_write_q    <= 1'b0;
      v_alpha_din_q  <= '0;
      h_alpha_din_q  <= '0;
      ext_size_din_q <= '0;
      in_write_q     <= 1'b0;
      in_din_q       <= '0;
    end else begin
      cfg_rr_q       <= cfg_rr_d;
      pel_rr_q       <= pel_rr_d;
      cfg_write_q    <= cfg_write_d;
      v_alpha_din_q  <= v_alpha_din_d;
      h_alpha_din_q  <= h_alpha_din_d;
      ext_size_din_q <= ext_size_din_d;
      in_write_q     <= in_write_d;
      in_din_q       <= in_din_d;
    end
  end

  assign cfg_write_o    = cfg_write_q;
  assign v_alpha_din_o  = v_alpha_din_q;
  assign h_alpha_din_o  = h_alpha_din_q;
  assign ext_size_din_o = ext_size_din_q;
  assign in_write_o     = in_write_q;
  assign in_din_o       = in_din_q;

endmodule

`default_nettype wire
